// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
//   Shared types and constants for the writeback scheduler slice.
//   - SRC_ALU / SRC_LSU / SRC_MDU : requester indices (0 = ALU)
//   - reg_idx_t                   : 5-bit architectural register index
//   - wb_req_t                    : one producer's writeback request
//   - popcount32()                : set-bit count of a 32-bit vector
//   Data width is the global 32-bit datapath width.
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_XLEN = 32;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_MDU = 2;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic                 valid;
        reg_idx_t             rd;
        logic [WB_XLEN-1:0]   value;
    } wb_req_t;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Picks at most one of NUM_SRC valid writeback requesters per cycle.
//   Optional feature macro: WB_ROUND_ROBIN_EN
//     defined   : round-robin, search starts at rr_ptr; rr_ptr moves to
//                 winner+1 after every grant
//     undefined : fixed priority, highest valid index wins
//   Ports:
//     clock, reset : present only with WB_ROUND_ROBIN_EN (rr_ptr state)
//     stall        : in  1        suppress all grants
//     valid        : in  NUM_SRC  requester has a result
//     grant        : out NUM_SRC  one-hot grant (or zero)
//     transfer     : out 1        some requester was granted this cycle
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int NUM_SRC = 3
) (
`ifdef WB_ROUND_ROBIN_EN
    input  logic               clock,
    input  logic               reset,
`endif
    input  logic               stall,
    input  logic [NUM_SRC-1:0] valid,
    output logic [NUM_SRC-1:0] grant,
    output logic               transfer
);

    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [SEL_W-1:0] winner;
    logic             found;

`ifdef WB_ROUND_ROBIN_EN
    logic [SEL_W-1:0] rr_ptr;

    // Rotating search: candidate k is (rr_ptr + k) mod NUM_SRC; the first
    // valid one wins.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        grant  = '0;
        if (!stall) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_SRC) begin
                    idx = idx - NUM_SRC;
                end
                if (!found && valid[idx]) begin
                    found  = 1'b1;
                    winner = SEL_W'(idx);
                end
            end
            if (found) begin
                grant[winner] = 1'b1;
            end
        end
    end

    // found already implies !stall, so the pointer holds on stall or idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (found) begin
            if (int'(winner) == NUM_SRC - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= winner + 1'b1;
            end
        end
    end
`else
    // Later iterations overwrite earlier ones, so the highest valid index
    // wins; long-latency units drain first and free scoreboard entries.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        grant  = '0;
        if (!stall) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (valid[i]) begin
                    found  = 1'b1;
                    winner = SEL_W'(i);
                end
            end
            if (found) begin
                grant[winner] = 1'b1;
            end
        end
    end
`endif

    assign transfer = found;

endmodule

// File: rtl/writeback_scheduler.sv
// ---------------------------------------------------------------------------
// writeback_scheduler
//   Shares the register file's single write port between NUM_SRC producers
//   and keeps a 32-entry scoreboard of in-flight multi-cycle destinations to
//   flag RAW/WAW hazards back to issue.
//   Optional feature macro: WB_ROUND_ROBIN_EN (see wb_arbiter).
//   Ports:
//     clock, reset        : clock, synchronous active-high reset
//     stall               : global stall, freezes grants and scoreboard
//     src_valid/src_ready : per-producer handshake
//     src_rd/src_value    : flattened per-producer destination and result
//     rd/rd_write/rd_value: register file write port
//     issue_valid/rs1/rs2/rd/reserve : issuing instruction
//     issue_hazard        : issue must hold this cycle
//     pending_count       : number of reserved registers
// ---------------------------------------------------------------------------
module writeback_scheduler
    import wb_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int XLEN    = WB_XLEN
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic [NUM_SRC-1:0]      src_valid,
    output logic [NUM_SRC-1:0]      src_ready,
    input  logic [NUM_SRC*5-1:0]    src_rd,
    input  logic [NUM_SRC*XLEN-1:0] src_value,
    output logic [4:0]              rd,
    output logic                    rd_write,
    output logic [XLEN-1:0]         rd_value,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rs1,
    input  logic [4:0]              issue_rs2,
    input  logic [4:0]              issue_rd,
    input  logic                    issue_reserve,
    output logic                    issue_hazard,
    output logic [5:0]              pending_count
);

    wb_req_t            reqs [NUM_SRC];
    logic [NUM_SRC-1:0] req_valid;
    logic               transfer;
    reg_idx_t           win_rd;
    logic [XLEN-1:0]    win_value;
    logic [31:0]        pending;
    logic [31:0]        pending_next;
    logic [31:0]        clr_vec;
    logic [31:0]        set_vec;
    logic [31:0]        eff;
    logic               set_en;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            reqs[i].valid = src_valid[i];
            reqs[i].rd    = src_rd[i*5 +: 5];
            reqs[i].value = src_value[i*XLEN +: XLEN];
            req_valid[i]  = reqs[i].valid;
        end
    end

    wb_arbiter #(.NUM_SRC(NUM_SRC)) u_arbiter (
`ifdef WB_ROUND_ROBIN_EN
        .clock    (clock),
        .reset    (reset),
`endif
        .stall    (stall),
        .valid    (req_valid),
        .grant    (src_ready),
        .transfer (transfer)
    );

    // Grant is one-hot or zero, so this OR-style mux yields zeros when idle.
    always_comb begin
        win_rd    = '0;
        win_value = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_ready[i]) begin
                win_rd    = reqs[i].rd;
                win_value = reqs[i].value;
            end
        end
    end

    // An rd=0 winner is still consumed, but the write is discarded.
    assign rd       = win_rd;
    assign rd_value = win_value;
    assign rd_write = transfer && (win_rd != 5'd0);

    // A same-cycle writeback is forwarded by the register file, so the bit
    // being cleared this cycle no longer counts as a hazard.
    always_comb begin
        clr_vec = '0;
        if (rd_write) begin
            clr_vec[win_rd] = 1'b1;
        end
        eff = pending & ~clr_vec;
        issue_hazard = issue_valid &&
                       (eff[issue_rs1] || eff[issue_rs2] ||
                        (issue_reserve && eff[issue_rd]));
    end

    // Set is applied after clear, so a same-register set/clear keeps the bit.
    always_comb begin
        set_en  = issue_valid && issue_reserve && !issue_hazard && !stall &&
                  (issue_rd != 5'd0);
        set_vec = '0;
        if (set_en) begin
            set_vec[issue_rd] = 1'b1;
        end
        pending_next = (pending & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending       <= '0;
            pending_count <= '0;
        end else begin
            pending       <= pending_next;
            pending_count <= popcount32(pending_next);
        end
    end

endmodule

// File: tb/tb_writeback_scheduler.sv
// ---------------------------------------------------------------------------
// tb_writeback_scheduler
//   Directed-vector bench for writeback_scheduler with hand-computed
//   expectations. Arbitration expectations follow WB_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
module tb_writeback_scheduler;

    logic        clock;
    logic        reset;
    logic        stall;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [14:0] src_rd;
    logic [95:0] src_value;
    logic [4:0]  rd;
    logic        rd_write;
    logic [31:0] rd_value;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_reserve;
    logic        issue_hazard;
    logic [5:0]  pending_count;

    int checks;
    int errors;

    writeback_scheduler #(.NUM_SRC(3), .XLEN(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .src_rd        (src_rd),
        .src_value     (src_value),
        .rd            (rd),
        .rd_write      (rd_write),
        .rd_value      (rd_value),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rd      (issue_rd),
        .issue_reserve (issue_reserve),
        .issue_hazard  (issue_hazard),
        .pending_count (pending_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives all inputs one time unit after a rising edge, then lets the
    // combinational outputs settle before the caller samples them.
    task automatic applyStimulus(input logic st, input logic [2:0] sv,
                                 input logic [14:0] srd, input logic [95:0] sval,
                                 input logic iv, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] ird,
                                 input logic ires);
        stall         = st;
        src_valid     = sv;
        src_rd        = srd;
        src_value     = sval;
        issue_valid   = iv;
        issue_rs1     = rs1;
        issue_rs2     = rs2;
        issue_rd      = ird;
        issue_reserve = ires;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 3'b000, '0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int          order [3];
    logic [2:0]  mask;
    logic [2:0]  exp_ready;
    logic [95:0] vals;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;

        // 1: reset with random inputs
        applyStimulus(1'($urandom), 3'($urandom), 15'($urandom),
                      {$urandom, $urandom, $urandom}, 1'($urandom),
                      5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
        tick();
        applyStimulus(1'($urandom), 3'($urandom), 15'($urandom),
                      {$urandom, $urandom, $urandom}, 1'b1,
                      5'($urandom), 5'($urandom), 5'($urandom), 1'b1);
        tick();
        reset = 1'b0;
        idle();
        checkOutput("rst_ready", 32'(src_ready), 32'h0);
        checkOutput("rst_rd_write", 32'(rd_write), 32'h0);
        checkOutput("rst_rd", 32'(rd), 32'h0);
        checkOutput("rst_rd_value", rd_value, 32'h0);
        checkOutput("rst_hazard", 32'(issue_hazard), 32'h0);
        checkOutput("rst_count", 32'(pending_count), 32'h0);
        tick();
        checkOutput("rst_count_after", 32'(pending_count), 32'h0);

        // 2: reserve r5, RAW hazard, LSU writeback clears it
        applyStimulus(1'b0, 3'b000, '0, '0, 1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
        checkOutput("res5_hazard", 32'(issue_hazard), 32'h0);
        tick();
        applyStimulus(1'b0, 3'b000, '0, '0, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
        checkOutput("res5_count", 32'(pending_count), 32'd1);
        checkOutput("raw5_hazard", 32'(issue_hazard), 32'h1);
        applyStimulus(1'b0, 3'b010, {5'd0, 5'd5, 5'd0},
                      {32'h0, 32'hDEADBEEF, 32'h0},
                      1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
        checkOutput("fwd5_hazard", 32'(issue_hazard), 32'h0);
        checkOutput("fwd5_ready", 32'(src_ready), 32'h2);
        checkOutput("fwd5_rd_write", 32'(rd_write), 32'h1);
        checkOutput("fwd5_rd", 32'(rd), 32'd5);
        checkOutput("fwd5_rd_value", rd_value, 32'hDEADBEEF);
        tick();
        idle();
        checkOutput("clr5_count", 32'(pending_count), 32'd0);

        // 3: three producers held until granted
        doReset();
`ifdef WB_ROUND_ROBIN_EN
        order = '{0, 1, 2};
`else
        order = '{2, 1, 0};
`endif
        vals = {32'h3000_0003, 32'h2000_0002, 32'h1000_0001};
        mask = 3'b111;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, mask, {5'd3, 5'd2, 5'd1}, vals,
                          1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            exp_ready = 3'b001 << order[k];
            checkOutput($sformatf("arb%0d_ready", k), 32'(src_ready), 32'(exp_ready));
            checkOutput($sformatf("arb%0d_rd", k), 32'(rd), 32'(order[k] + 1));
            checkOutput($sformatf("arb%0d_value", k), rd_value,
                        vals[order[k]*32 +: 32]);
            tick();
            mask = mask & ~exp_ready;
        end
        idle();
        checkOutput("arb_count", 32'(pending_count), 32'd0);

        // 4: stall freezes grants and reservations
        applyStimulus(1'b0, 3'b000, '0, '0, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
        tick();
        applyStimulus(1'b1, 3'b111, {5'd8, 5'd6, 5'd4}, vals,
                      1'b1, 5'd0, 5'd0, 5'd10, 1'b1);
        checkOutput("stall_count_pre", 32'(pending_count), 32'd1);
        checkOutput("stall_ready", 32'(src_ready), 32'h0);
        checkOutput("stall_rd_write", 32'(rd_write), 32'h0);
        tick();
        tick();
        checkOutput("stall_count", 32'(pending_count), 32'd1);
        applyStimulus(1'b0, 3'b111, {5'd8, 5'd6, 5'd4}, vals,
                      1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
`ifdef WB_ROUND_ROBIN_EN
        checkOutput("resume_ready", 32'(src_ready), 32'h1);
        checkOutput("resume_rd", 32'(rd), 32'd4);
`else
        checkOutput("resume_ready", 32'(src_ready), 32'h4);
        checkOutput("resume_rd", 32'(rd), 32'd8);
`endif
        checkOutput("resume_rd_write", 32'(rd_write), 32'h1);
        tick();
        applyStimulus(1'b0, 3'b001, {5'd0, 5'd0, 5'd9}, vals,
                      1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("resume_count", 32'(pending_count), 32'd1);
        checkOutput("alu9_rd_write", 32'(rd_write), 32'h1);
        tick();
        idle();
        checkOutput("alu9_count", 32'(pending_count), 32'd0);

        // 5: same-cycle clear and set of r7, set wins
        applyStimulus(1'b0, 3'b000, '0, '0, 1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
        tick();
        idle();
        applyStimulus(1'b0, 3'b000, '0, '0, 1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
        checkOutput("waw7_hazard", 32'(issue_hazard), 32'h1);
        applyStimulus(1'b0, 3'b100, {5'd7, 5'd0, 5'd0},
                      {32'h7777_7777, 32'h0, 32'h0},
                      1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
        checkOutput("setclr7_hazard", 32'(issue_hazard), 32'h0);
        checkOutput("setclr7_ready", 32'(src_ready), 32'h4);
        checkOutput("setclr7_rd_write", 32'(rd_write), 32'h1);
        tick();
        applyStimulus(1'b0, 3'b100, {5'd7, 5'd0, 5'd0},
                      {32'h7777_7777, 32'h0, 32'h0},
                      1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("setclr7_count", 32'(pending_count), 32'd1);
        tick();
        idle();
        checkOutput("clr7_count", 32'(pending_count), 32'd0);

        // 6: register 0 is never reserved or written
        applyStimulus(1'b0, 3'b001, {5'd0, 5'd0, 5'd0},
                      {32'h0, 32'h0, 32'hCAFE_F00D},
                      1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        checkOutput("r0_ready", 32'(src_ready), 32'h1);
        checkOutput("r0_rd_write", 32'(rd_write), 32'h0);
        checkOutput("r0_hazard", 32'(issue_hazard), 32'h0);
        tick();
        idle();
        checkOutput("r0_count", 32'(pending_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
